// File: rtl/fp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mac_pipe
// Brief    : 3-stage pipelined FP add/sub/mul/mac with accumulator and
//            valid/ready flow control; truncating, no denormals.
// Revision : 1.0
// ============================================================================
module fp_mac_pipe #(
    parameter int EXP_W = 8,
    parameter int M_W   = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic                   in_acc_clr,
    input  logic [EXP_W+M_W:0]     in_a,
    input  logic [EXP_W+M_W:0]     in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+M_W:0]     out_result,
    output logic [2:0]             out_flags,
    output logic [EXP_W+M_W:0]     acc_value
);

    localparam int W   = 1 + EXP_W + M_W;
    localparam int SW  = M_W + 3;
    localparam int PW  = 2 * M_W + 2;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(SW) + 1;

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_mul = 2'b10;
    localparam logic [1:0] c_op_mac = 2'b11;

    localparam logic [EXP_W-1:0]    c_exp_ones = '1;
    localparam logic signed [EW-1:0] c_e_zero  = '0;
    localparam logic signed [EW-1:0] c_e_one   = EW'(1);
    localparam logic signed [EW-1:0] c_e_max   = EW'((2 ** EXP_W) - 1);
    localparam logic signed [EW-1:0] c_bias    = EW'((2 ** (EXP_W - 1)) - 1);

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) lzc = LZW'(SW - 1 - i);
        end
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage 1: capture operands
    // ------------------------------------------------------------------
    logic         r_s1_valid;
    logic [1:0]   r_s1_op;
    logic         r_s1_clr;
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_clr   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op  <= in_op;
                r_s1_clr <= in_acc_clr;
                r_s1_a   <= in_a;
                r_s1_b   <= (in_op == c_op_sub) ? {~in_b[W-1], in_b[W-2:0]} : in_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: multiplier
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]     w_ea2, w_eb2;
    logic [M_W-1:0]       w_ma2, w_mb2, w_pman;
    logic [PW-1:0]        w_prod;
    logic                 w_msb, w_psign;
    logic signed [EW-1:0] w_pexp;
    logic [W-1:0]         w_p;
    logic                 w_pexc, w_povf, w_pudf;

    assign w_ea2  = r_s1_a[W-2:M_W];
    assign w_eb2  = r_s1_b[W-2:M_W];
    assign w_ma2  = r_s1_a[M_W-1:0];
    assign w_mb2  = r_s1_b[M_W-1:0];
    assign w_prod = {{(M_W+1){1'b0}}, 1'b1, w_ma2} * {{(M_W+1){1'b0}}, 1'b1, w_mb2};
    assign w_msb  = w_prod[PW-1];
    assign w_pman = w_msb ? w_prod[PW-2 -: M_W] : w_prod[PW-3 -: M_W];
    assign w_psign = r_s1_a[W-1] ^ r_s1_b[W-1];
    assign w_pexp = $signed({2'b00, w_ea2}) + $signed({2'b00, w_eb2}) - c_bias
                  + $signed({{(EW-1){1'b0}}, w_msb});

    always_comb begin
        w_p    = {w_psign, {(W-1){1'b0}}};
        w_pexc = 1'b0;
        w_povf = 1'b0;
        w_pudf = 1'b0;
        if (w_ea2 == c_exp_ones || w_eb2 == c_exp_ones) begin
            w_p    = {w_psign, c_exp_ones, {M_W{1'b0}}};
            w_pexc = 1'b1;
        end else if (w_ea2 == '0 || w_eb2 == '0) begin
            w_p = {w_psign, {(W-1){1'b0}}};
        end else if (w_pexp >= c_e_max) begin
            w_p    = {w_psign, c_exp_ones, {M_W{1'b0}}};
            w_povf = 1'b1;
        end else if (w_pexp <= c_e_zero) begin
            w_pudf = 1'b1;
        end else begin
            w_p = {w_psign, w_pexp[EXP_W-1:0], w_pman};
        end
    end

    logic         r_s2_valid;
    logic [1:0]   r_s2_op;
    logic         r_s2_clr;
    logic [W-1:0] r_s2_a, r_s2_b, r_s2_p;
    logic         r_s2_pexc, r_s2_povf, r_s2_pudf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= '0;
            r_s2_clr   <= 1'b0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
            r_s2_p     <= '0;
            r_s2_pexc  <= 1'b0;
            r_s2_povf  <= 1'b0;
            r_s2_pudf  <= 1'b0;
        end else if (adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_op   <= r_s1_op;
                r_s2_clr  <= r_s1_clr;
                r_s2_a    <= r_s1_a;
                r_s2_b    <= r_s1_b;
                r_s2_p    <= w_p;
                r_s2_pexc <= w_pexc;
                r_s2_povf <= w_povf;
                r_s2_pudf <= w_pudf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: add core; acc is read here so chained macs need no bubble
    // ------------------------------------------------------------------
    logic [W-1:0] r_acc;
    logic [W-1:0] w_acc_in, w_op_a, w_op_b;
    logic         w_is_mul;

    assign w_acc_in = r_s2_clr ? '0 : r_acc;
    assign w_is_mul = r_s2_op[1];

    always_comb begin
        w_op_a = r_s2_a;
        w_op_b = r_s2_b;
        case (r_s2_op)
            c_op_mul: begin
                w_op_a = r_s2_p;
                w_op_b = '0;
            end
            c_op_mac: begin
                w_op_a = w_acc_in;
                w_op_b = r_s2_p;
            end
            default: ;
        endcase
    end

    logic [EXP_W-1:0] w_ea3, w_eb3, w_ex, w_ey, w_dexp;
    logic [W-2:0]     w_mag_a, w_mag_b, w_mag_x, w_mag_y;
    logic             w_swap, w_sx, w_sy;
    logic [SW-1:0]    w_sig_x, w_sig_y, w_sig_ys, w_diff, w_nsig;
    logic [SW:0]      w_sum;
    logic [LZW-1:0]   w_lz;
    logic signed [EW-1:0] w_e;
    logic [W-1:0]     w_core_res;
    logic             w_core_ovf, w_core_udf;

    assign w_ea3   = w_op_a[W-2:M_W];
    assign w_eb3   = w_op_b[W-2:M_W];
    assign w_mag_a = (w_ea3 == '0) ? '0 : w_op_a[W-2:0];
    assign w_mag_b = (w_eb3 == '0) ? '0 : w_op_b[W-2:0];
    assign w_swap  = w_mag_b > w_mag_a;
    assign w_mag_x = w_swap ? w_mag_b : w_mag_a;
    assign w_mag_y = w_swap ? w_mag_a : w_mag_b;
    assign w_sx    = w_swap ? w_op_b[W-1] : w_op_a[W-1];
    assign w_sy    = w_swap ? w_op_a[W-1] : w_op_b[W-1];
    assign w_ex    = w_mag_x[W-2:M_W];
    assign w_ey    = w_mag_y[W-2:M_W];
    assign w_sig_x = (w_ex == '0) ? '0 : {1'b1, w_mag_x[M_W-1:0], 2'b00};
    assign w_sig_y = (w_ey == '0) ? '0 : {1'b1, w_mag_y[M_W-1:0], 2'b00};
    assign w_dexp  = w_ex - w_ey;
    assign w_sig_ys = ({{(32-EXP_W){1'b0}}, w_dexp} >= 32'(M_W + 2)) ? '0 : (w_sig_y >> w_dexp);
    assign w_sum   = {1'b0, w_sig_x} + {1'b0, w_sig_ys};
    assign w_diff  = w_sig_x - w_sig_ys;
    assign w_lz    = lzc(w_diff);

    always_comb begin
        w_core_res = '0;
        w_core_ovf = 1'b0;
        w_core_udf = 1'b0;
        w_nsig     = '0;
        w_e        = '0;
        if (w_sx == w_sy) begin
            if (w_ex == '0) begin
                w_core_res = {w_sx & w_sy, {(W-1){1'b0}}};
            end else begin
                if (w_sum[SW]) begin
                    w_nsig = w_sum[SW:1];
                    w_e    = $signed({2'b00, w_ex}) + c_e_one;
                end else begin
                    w_nsig = w_sum[SW-1:0];
                    w_e    = $signed({2'b00, w_ex});
                end
                if (w_e >= c_e_max) begin
                    w_core_res = {w_sx, c_exp_ones, {M_W{1'b0}}};
                    w_core_ovf = 1'b1;
                end else begin
                    w_core_res = {w_sx, w_e[EXP_W-1:0], w_nsig[SW-2 -: M_W]};
                end
            end
        end else if (w_diff != '0) begin
            w_nsig = w_diff << w_lz;
            w_e    = $signed({2'b00, w_ex}) - $signed({{(EW-LZW){1'b0}}, w_lz});
            if (w_e <= c_e_zero) begin
                w_core_res = {w_sx, {(W-1){1'b0}}};
                w_core_udf = 1'b1;
            end else begin
                w_core_res = {w_sx, w_e[EXP_W-1:0], w_nsig[SW-2 -: M_W]};
            end
        end
    end

    logic         w_exc, w_exc_sign;
    logic [W-1:0] w_res;
    logic [2:0]   w_flags;

    always_comb begin
        if (w_is_mul)
            w_exc = r_s2_pexc || (r_s2_op == c_op_mac && w_acc_in[W-2:M_W] == c_exp_ones);
        else
            w_exc = (r_s2_a[W-2:M_W] == c_exp_ones) || (r_s2_b[W-2:M_W] == c_exp_ones);
        w_exc_sign = r_s2_a[W-1] ^ (w_is_mul & r_s2_b[W-1]);
        if (w_exc) begin
            w_res   = {w_exc_sign, c_exp_ones, {M_W{1'b0}}};
            w_flags = 3'b100;
        end else if (w_is_mul && r_s2_povf) begin
            w_res   = r_s2_p;
            w_flags = 3'b010;
        end else begin
            w_res   = w_core_res;
            w_flags = {1'b0, w_core_ovf, w_core_udf | (w_is_mul & r_s2_pudf)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            r_acc      <= '0;
        end else if (adv) begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                out_result <= w_res;
                out_flags  <= w_flags;
                if (r_s2_op == c_op_mac) r_acc <= w_res;
            end
        end
    end

    assign acc_value = r_acc;

    logic w_unused;
    assign w_unused = ^{w_nsig[1:0], w_prod[M_W-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_fp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mac_pipe
// Brief    : Scoreboard bench for fp_mac_pipe (bf16 instance plus fp16 one).
// Revision : 1.0
// ============================================================================
module tb_fp_mac_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  flags;
        logic [15:0] acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_acc_clr = 1'b0, out_ready = 1'b1;
    logic [1:0]  in_op = '0;
    logic [15:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_result, acc_value;
    logic [2:0]  out_flags;

    logic        in_valid16 = 1'b0, in_acc_clr16 = 1'b0, out_ready16 = 1'b1;
    logic [1:0]  in_op16 = '0;
    logic [15:0] in_a16 = '0, in_b16 = '0;
    logic        in_ready16, out_valid16;
    logic [15:0] out_result16, acc_value16;
    logic [2:0]  out_flags16;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t q16[$];
    logic [15:0] tb_acc = '0;
    logic        held_valid = 1'b0;
    logic [15:0] held_res = '0;

    always #5 clk = ~clk;

    fp_mac_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_acc_clr(in_acc_clr), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .acc_value(acc_value)
    );

    fp_mac_pipe #(.EXP_W(5), .M_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_op(in_op16), .in_acc_clr(in_acc_clr16), .in_a(in_a16), .in_b(in_b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_result(out_result16),
        .out_flags(out_flags16), .acc_value(acc_value16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic clr, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r, input logic [2:0] f);
        exp_t e;
        logic ok;
        logic took;
        took = 1'b0;
        in_valid = 1'b1; in_op = op; in_acc_clr = clr; in_a = a; in_b = b;
        for (int t = 0; t < 50; t++) begin
            #1;
            ok = in_ready;
            if (ok) begin
                if (op == 2'b11) tb_acc = r;
                e.res = r; e.flags = f; e.acc = tb_acc;
                q.push_back(e);
            end
            @(posedge clk); #1;
            if (ok) begin
                took = 1'b1;
                break;
            end
        end
        if (!took) check("send_timeout", 32'(took), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send16(input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] r);
        exp_t e;
        in_valid16 = 1'b1; in_op16 = op; in_a16 = a; in_b16 = b;
        #1;
        check("in_ready16", 32'(in_ready16), 32'd1);
        e.res = r; e.flags = 3'b000; e.acc = '0;
        q16.push_back(e);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (q.size() == 0 && q16.size() == 0) break;
            @(posedge clk);
        end
        check("drain_left", 32'(q.size() + q16.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("sb_has_entry", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("result", 32'(out_result), 32'(e.res));
                    check("flags", 32'(out_flags), 32'(e.flags));
                    check("acc_value", 32'(acc_value), 32'(e.acc));
                end
                held_valid = 1'b0;
            end else if (out_valid) begin
                check("in_ready_stall", 32'(in_ready), 32'd0);
                if (held_valid) check("stall_stable", 32'(out_result), 32'(held_res));
                held_valid = 1'b1;
                held_res   = out_result;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid16) begin
                check("sb16_has_entry", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("result16", 32'(out_result16), 32'(e.res));
                    check("flags16", 32'(out_flags16), 32'(e.flags));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_acc", 32'(acc_value), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed ops, back-to-back, consumer always ready
        send(2'b00, 1'b0, 16'h3F80, 16'h4000, 16'h4040, 3'b000);
        send(2'b01, 1'b0, 16'h4040, 16'h3F80, 16'h4000, 3'b000);
        send(2'b01, 1'b0, 16'h3FC0, 16'h3FC0, 16'h0000, 3'b000);
        send(2'b10, 1'b0, 16'h3FC0, 16'h4000, 16'h4040, 3'b000);
        send(2'b10, 1'b0, 16'h7F00, 16'h4000, 16'h7F80, 3'b010);
        send(2'b10, 1'b0, 16'h0000, 16'h4000, 16'h0000, 3'b000);
        send(2'b10, 1'b0, 16'h0080, 16'h0080, 16'h0000, 3'b001);
        send(2'b11, 1'b1, 16'h3F80, 16'h4000, 16'h4000, 3'b000);
        send(2'b11, 1'b0, 16'h3FC0, 16'h4000, 16'h40A0, 3'b000);
        send(2'b00, 1'b0, 16'h3F80, 16'h4000, 16'h4040, 3'b000);
        send(2'b00, 1'b0, 16'hC000, 16'h3F80, 16'hBF80, 3'b000);
        send(2'b00, 1'b0, 16'h7F80, 16'h3F80, 16'h7F80, 3'b100);
        drain();

        // Backpressure: out_ready pattern 1,0,0 repeating
        fork
            begin
                send(2'b00, 1'b0, 16'h3F80, 16'h3F80, 16'h4000, 3'b000);
                send(2'b00, 1'b0, 16'h4000, 16'h4000, 16'h4080, 3'b000);
                send(2'b00, 1'b0, 16'h4040, 16'h3F80, 16'h4080, 3'b000);
                send(2'b00, 1'b0, 16'h3F80, 16'h3F00, 16'h3FC0, 3'b000);
                send(2'b00, 1'b0, 16'h4080, 16'hC000, 16'h4000, 3'b000);
                send(2'b00, 1'b0, 16'h3F80, 16'h0000, 16'h3F80, 3'b000);
            end
            begin
                for (int i = 0; i < 45; i++) begin
                    out_ready = (i % 3 == 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three ops in flight
        out_ready = 1'b0;
        send(2'b11, 1'b1, 16'h3F80, 16'h4000, 16'h4000, 3'b000);
        send(2'b00, 1'b0, 16'h3F80, 16'h4000, 16'h4040, 3'b000);
        send(2'b00, 1'b0, 16'h3F80, 16'h3F80, 16'h4000, 3'b000);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_acc", 32'(acc_value), 32'h4000);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_result", 32'(out_result), 32'd0);
        check("midrst_acc", 32'(acc_value), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        tb_acc = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(2'b00, 1'b0, 16'h3F80, 16'h4000, 16'h4040, 3'b000);
        drain();

        // fp16 instance
        send16(2'b10, 16'h3C00, 16'h4000, 16'h4000);
        send16(2'b00, 16'h3C00, 16'h3C00, 16'h4000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mac_pipe.md
# fp_mac_pipe

Parametrised, 3-stage pipelined floating-point arithmetic unit for the LISA datapath. It is the successor to the combinational `fadd`/`fmul` pair. It supports configurable exponent and mantissa widths, add/sub/mul/multiply-accumulate modes, a true subtract path with leading-zero renormalisation, an internal accumulator, and valid/ready flow control on both sides.

## Interface
- `EXP_W`, default 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `M_W`, default 7: stored mantissa width, with hidden 1 implied. Word width W = 1+EXP_W+M_W (16 by default, bf16).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  transaction offered.
- `in_ready`  out  1  transaction accepted when `in_valid & in_ready` at a rising edge.
- `in_op`  in  2  00 add (a+b), 01 sub (a-b), 10 mul (a*b), 11 mac (acc+a*b).
- `in_acc_clr`  in  1  mac only: treat acc as +0 for this transaction.
- `in_a`, `in_b`  in  W each  operands, sign|exp|mant.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  W  result word.
- `out_flags`  out  3  {exc, ovf, udf}.
- `acc_value`  out  W  current accumulator contents.

## Operation
- Number rules:
  - Exponent field 0 means ±zero. Denormals are not supported; a zero exponent with nonzero mantissa is treated as zero.
  - Exponent field all-ones means inf/NaN.
  - Rounding is truncation (toward zero) throughout.
- Exception: if any operand used by the op (including acc in mac) has an all-ones exponent, the result is {sign of a XOR (mul/mac ? sign b : 0), all-ones exp, 0 mantissa} and exc=1.
- Stage 1: registers op, acc_clr, a and b. For sub, b's sign is inverted here.
- Stage 2:
  - mul/mac: product = {1,ma}*{1,mb} (2*M_W+2 bits). Normalise on the product MSB. Exponent = ea+eb-bias+msb, computed at EXP_W+2 bits signed.
  - Overflow (exp ≥ 2^EXP_W-1) gives ±inf and ovf=1.
  - Underflow (exp ≤ 0) or any zero operand gives ±0; udf=1 only when both operands were nonzero.
  - add/sub: a and b pass through unchanged.
- Stage 3 (add core):
  - Operands: add/sub use a and b; mul uses product and +0; mac uses acc (or +0 if acc_clr) and product.
  - Larger magnitude goes to X. Smaller significand shifts right by the exponent difference; shifts ≥ M_W+2 give 0. Keep 2 guard bits, truncated at output.
  - Same signs: add, and a carry gives shift right and exp+1. Overflow gives inf and ovf.
  - Opposite signs: subtract. A zero difference gives +0. Otherwise, leading-zero count shifts left and decrements the exponent; exp ≤ 0 gives ±0 and udf=1.
  - Result sign = sign of X.
- Accumulator:
  - Updated only when a mac result is written into the output register. acc = that result, including inf/zero outcomes.
  - Other ops never modify acc.
  - Because acc is read and written in stage 3, back-to-back macs chain correctly with no bubble.
- Flow control:
  - Global advance `adv = !out_valid | out_ready`, and `in_ready = adv`.
  - Each stage has a valid bit that moves forward on adv, so bubbles propagate.
  - When !adv, all stage registers, out_result, out_flags and acc hold.

## Timing
- Reset (rst_n low, asynchronous): all stage valids 0, `out_valid`=0, `out_result`=0, `out_flags`=0, acc=0 (`acc_value`=0), `in_ready`=1.
- A reset asserted mid-pipeline discards in-flight transactions and clears acc.
- Latency:
  - A transaction accepted at edge k appears with `out_valid`=1 after edge k+2, i.e. at the third stage register.
  - It remains until the edge where `out_ready`=1.
- Throughput: 1 per cycle while `out_ready` stays high.
- Stall: the result is stable while `out_valid & !out_ready`; no transaction is lost or duplicated.
- Simultaneous pop and push: with `out_valid & out_ready & in_valid` in the same cycle, both happen; the pipeline advances one step.
- `acc_value` reflects the new acc the cycle after the mac result is registered, concurrently with that `out_valid`.

## Test plan
- Add and sub, bf16 default: add 0x3F80+0x4000 gives 0x4040; sub 0x4040-0x3F80 gives 0x4000; sub 0x3FC0-0x3FC0 gives 0x0000, flags 000.
- Mul: 0x3FC0*0x4000 gives 0x4040. Then 0x7F00*0x4000 gives 0x7F80, ovf=1. Then 0x0000*0x4000 gives 0x0000, udf=0.
- Mac chain, back-to-back: mac(0x3F80,0x4000, acc_clr=1) gives 0x4000, then mac(0x3FC0,0x4000) gives 0x40A0, with `acc_value`=0x40A0. A following add leaves acc unchanged.
- Backpressure:
  - Stimulus: stream 6 adds while `out_ready` is toggled 1,0,0,1,…
  - Required: results arrive in order and exact; `in_ready` low in every cycle where `out_valid & !out_ready`; `out_result` stable during the stall.
- Exception and reset:
  - Add with a=0x7F80 gives exc=1 with an all-ones exponent.
  - Assert `rst_n` low with 3 ops in flight: outputs go to 0 immediately, and no stale `out_valid` appears after release.
- Parametrisation: EXP_W=5, M_W=10 (fp16): 0x3C00*0x4000 gives 0x4000, and 0x3C00+0x3C00 gives 0x4000.
